// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter that shares one single-clock FIFO among NREQ valid/ready
// producers. It presents the FIFO read side as a valid/ready stream and can drain it on flush.
module fifo_push_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int BURST = 4,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]         req_ready,
   output logic                    fifo_push,
   output logic [WIDTH-1:0]        fifo_datain,
   output logic                    fifo_pop,
   input  logic [LW-1:0]           fifo_level,
   input  logic [WIDTH-1:0]        fifo_dataout,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   input  logic                    out_ready,
   input  logic                    flush,
   output logic                    flush_done,
   output logic                    busy,
   output logic [$clog2(NREQ)-1:0] grant_id
);

   localparam int IW = $clog2(NREQ);
   localparam int BW = $clog2(BURST + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BURST,
      S_FLUSH
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] rr_ptr_nxt;
   logic [IW-1:0] owner;
   logic [IW-1:0] owner_nxt;
   logic [BW-1:0] beats;
   logic [BW-1:0] beats_nxt;
   logic          flush_pend;
   logic          flush_pend_nxt;
   logic          flush_done_q;
   logic          settle;

   logic             quiet;
   logic             fifo_empty;
   logic             fifo_full;
   logic             space;
   logic [2*NREQ-1:0] valid_dbl;
   logic [NREQ-1:0]  valid_rot;
   logic             pick_found;
   logic [IW-1:0]    pick_off;
   logic [IW:0]      pick_sum;
   logic [IW-1:0]    pick_idx;
   logic [IW-1:0]    owner_inc;
   logic             owner_valid;
   logic [WIDTH-1:0] owner_data;

   // Outputs stay silent during reset and for one settling cycle afterwards.
   assign quiet      = rst | settle;
   assign fifo_empty = (fifo_level == '0);
   assign fifo_full  = (fifo_level >= LW'(DEPTH));
   assign space      = ~fifo_full | fifo_pop;

   always_comb begin
      out_valid = 1'b0;
      fifo_pop  = 1'b0;
      out_data  = '0;
      if (!quiet) begin
         out_data = fifo_dataout;
         if (state == S_FLUSH) begin
            fifo_pop = ~fifo_empty;
         end else begin
            out_valid = ~fifo_empty;
            fifo_pop  = ~fifo_empty & out_ready;
         end
      end
   end

   // Rotate the request vector so the search always starts at bit 0 = rr_ptr.
   always_comb begin
      valid_dbl  = {req_valid, req_valid};
      valid_rot  = valid_dbl[{1'b0, rr_ptr} +: NREQ];
      pick_found = |req_valid;
      pick_off   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (valid_rot[k]) begin
            pick_off = IW'(k);
         end
      end
      pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
      if (pick_sum >= (IW+1)'(NREQ)) begin
         pick_idx = IW'(pick_sum - (IW+1)'(NREQ));
      end else begin
         pick_idx = pick_sum[IW-1:0];
      end
   end

   assign owner_inc   = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
   assign owner_valid = req_valid[owner];
   assign owner_data  = req_data[owner*WIDTH +: WIDTH];

   always_comb begin
      state_nxt      = state;
      rr_ptr_nxt     = rr_ptr;
      owner_nxt      = owner;
      beats_nxt      = beats;
      flush_pend_nxt = flush_pend;
      req_ready      = '0;
      fifo_push      = 1'b0;
      fifo_datain    = '0;
      busy           = 1'b0;
      grant_id       = '0;
      case (state)
         S_IDLE: begin
            if (flush_pend | flush) begin
               state_nxt = S_FLUSH;
            end else if (pick_found) begin
               owner_nxt = pick_idx;
               beats_nxt = '0;
               state_nxt = S_BURST;
            end
         end
         S_BURST: begin
            busy        = 1'b1;
            grant_id    = owner;
            fifo_datain = owner_data;
            if (flush) begin
               flush_pend_nxt = 1'b1;
            end
            // A stall on a full FIFO simply holds here without consuming a beat.
            if (!owner_valid) begin
               state_nxt  = S_IDLE;
               rr_ptr_nxt = owner_inc;
            end else if (space) begin
               req_ready[owner] = 1'b1;
               fifo_push        = 1'b1;
               beats_nxt        = beats + 1'b1;
               if (beats == BW'(BURST - 1)) begin
                  state_nxt  = S_IDLE;
                  rr_ptr_nxt = owner_inc;
               end
            end
         end
         S_FLUSH: begin
            if (fifo_empty) begin
               state_nxt      = S_IDLE;
               flush_pend_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      if (quiet) begin
         req_ready   = '0;
         fifo_push   = 1'b0;
         fifo_datain = '0;
         busy        = 1'b0;
         grant_id    = '0;
      end
   end

   assign flush_done = flush_done_q & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         rr_ptr       <= '0;
         owner        <= '0;
         beats        <= '0;
         flush_pend   <= 1'b0;
         flush_done_q <= 1'b0;
         settle       <= 1'b1;
      end else begin
         state        <= state_nxt;
         rr_ptr       <= rr_ptr_nxt;
         owner        <= owner_nxt;
         beats        <= beats_nxt;
         flush_pend   <= flush_pend_nxt;
         flush_done_q <= (state == S_FLUSH) & fifo_empty;
         settle       <= 1'b0;
      end
   end

endmodule
